pipelined_fetch_unit: RTL and testbench
=======================================

PIPELINED_FETCH_UNIT -- requirements
Module: pipelined_fetch_unit

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10, instruction-memory word-index width.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 2, instruction-buffer entries; legal values are powers of two ≥ 2.
REQ-004 system_clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 redirect_valid  input  1  branch/jump resolved; load new PC.
REQ-007 redirect_target  input  32  byte address of the redirect target.
REQ-008 imem_en  output  1  fetch request issued this cycle.
REQ-009 imem_addr  output  ADDR_WIDTH  word index, pc[ADDR_WIDTH+1:2].
REQ-010 imem_data  input  32  synchronous memory read data, valid the cycle after imem_en.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid instruction.
REQ-012 instr_ready  input  1  downstream accepts the instruction this cycle.
REQ-013 instr  output  32  fetched instruction word.
REQ-014 instr_pc  output  32  byte address of instr.
REQ-015 fetch_fault  output  1  misaligned redirect trap; present only with IFU_MISALIGN_TRAP_EN.

Function
REQ-016 SHALL hold the fetch PC register pc; imem_addr SHALL be driven combinationally from pc.
REQ-017 Issue rule: imem_en=1 iff (count + inflight − pop) < FIFO_DEPTH, no redirect this cycle, and not faulted.
REQ-018 Definitions for REQ-017: pop = instr_valid && instr_ready; inflight = request issued on the previous edge and not yet written.
REQ-019 On an issuing edge, pc SHALL advance by 4, modulo 2^32; imem_addr wraps naturally at memory depth.
REQ-020 Response capture: the edge after an issue SHALL push {imem_data, issuing pc} into the FIFO; issue-to-instr_valid latency is 2 edges.
REQ-021 Output: instr_valid = (count != 0); instr/instr_pc show the FIFO head; pop SHALL remove the head on the edge.
REQ-022 Push and pop on the same edge SHALL both take effect; count is unchanged.
REQ-023 The FIFO SHALL never overflow; a push SHALL never be dropped unless a redirect is active.
REQ-024 Redirect, on that edge: FIFO flushed, count=0, in-flight response discarded, pc←redirect_target (low 2 bits cleared), no issue that cycle.
REQ-025 Redirect priority: redirect SHALL win over push and pop; the head is still considered accepted if instr_ready=1.
REQ-026 First post-redirect fetch SHALL issue the cycle after the redirect; instr_valid SHALL be 0 for at least 2 cycles.
REQ-027 Stall (instr_ready=0): buffer fills to FIFO_DEPTH, then imem_en=0; instr and instr_pc SHALL remain stable.

Reset
REQ-028 Reset assertion SHALL immediately, asynchronously set: pc=RESET_PC, count=0, inflight=0, instr_valid=0, fetch_fault=0.
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight instructions.
REQ-030 The first imem_en SHALL occur in the first cycle after reset deasserts.
REQ-031 instr and instr_pc SHALL reset to 0.

Configuration
REQ-032 Macro IFU_MISALIGN_TRAP_EN defined: redirect_target[1:0]≠0 sets fetch_fault=1 and halts issue; a later aligned redirect clears it.
REQ-033 Macro undefined: fetch_fault is absent; redirect_target[1:0] is silently ignored.

Verification
REQ-034 Release reset, instr_ready=1, memory word k = k: instr_valid rises 2 edges later; instr_pc 0,4,8,… one per cycle; instr = 0,1,2,…
REQ-035 Hold instr_ready=0 for 6 cycles: exactly FIFO_DEPTH entries buffered, imem_en=0, instr_pc stable at 0x0.
REQ-036 Release instr_ready: stream continues gap-free at 0x4.
REQ-037 redirect_valid with target 0x40 while instr_pc=0x8 and 2 entries buffered: instr_valid=0 for 2 cycles, next instr_pc=0x40, no 0xC/0x10 emitted.
REQ-038 ADDR_WIDTH=4, run past pc=0x3C: imem_addr wraps 15→0, instr_pc=0x40; assert reset mid-stream → instr_valid=0 at once, restart at RESET_PC.
REQ-039 With IFU_MISALIGN_TRAP_EN, redirect to 0x42: fetch_fault=1, imem_en=0; redirect to 0x80 clears fault, instr_pc=0x80 two edges later.

Source files
------------

// File: rtl/pipelined_fetch_unit.sv
// Instruction fetch unit: PC generator, one-deep in-flight tracking for a synchronous
// instruction memory, and a small instruction buffer. Optional macro: IFU_MISALIGN_TRAP_EN.
module pipelined_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic                  fetch_fault,
`endif
  output logic [31:0]           instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      pc;
  logic             vld_p1;
  logic [31:0]      pc_p1;
  logic [31:0]      fifo_instr_p2 [FIFO_DEPTH];
  logic [31:0]      fifo_pc_p2    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             faulted;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  // Issue decision counts both buffered entries and the response still in flight.
  always_comb begin
    pop       = instr_valid && instr_ready;
    push      = vld_p1 && !redirect_valid;
    occupancy = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
    issue     = reset && !redirect_valid && !faulted &&
                (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  end

  assign imem_en     = issue;
  assign imem_addr   = pc[ADDR_WIDTH+1:2];
  assign instr_valid = (count != '0);
  assign instr       = fifo_instr_p2[rd_ptr];
  assign instr_pc    = fifo_pc_p2[rd_ptr];

  // Stage p0 -> p1: PC advance and in-flight request tracking; p1 -> p2: buffer write.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_p2[i] <= '0;
        fifo_pc_p2[i]    <= '0;
      end
    end else if (redirect_valid) begin
      pc     <= redirect_target & 32'hFFFF_FFFC;
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) begin
        pc <= pc + 32'd4;
      end
      vld_p1 <= issue;
      if (push) begin
        fifo_instr_p2[wr_ptr] <= imem_data;
        fifo_pc_p2[wr_ptr]    <= pc_p1;
        wr_ptr                <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Address of the request in flight; meaningful only while vld_p1 is set.
  always_ff @(posedge system_clock) begin
    if (issue) begin
      pc_p1 <= pc;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  // Fault latches on a misaligned redirect and holds issue off until an aligned one.
  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      faulted <= 1'b0;
    end else if (redirect_valid) begin
      faulted <= (redirect_target[1:0] != 2'b00);
    end
  end
  assign fetch_fault = faulted;
`else
  assign faulted = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Scoreboard bench for pipelined_fetch_unit: directed scenarios followed by random
// ready/redirect/reset traffic, checked against an in-order stream model.
module tb_pipelined_fetch_unit;

  localparam int          AW    = 4;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          system_clock = 1'b0;
  logic          reset = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_target = '0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
`ifdef IFU_MISALIGN_TRAP_EN
  logic          fetch_fault;
`endif

  pipelined_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .system_clock   (system_clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
`ifdef IFU_MISALIGN_TRAP_EN
    .fetch_fault    (fetch_fault),
`endif
    .instr_pc       (instr_pc)
  );

  always #5 system_clock = ~system_clock;

  // Memory word k holds the value k.
  always @(posedge system_clock) begin
    if (imem_en) imem_data <= {{(32-AW){1'b0}}, imem_addr};
  end

  typedef struct packed {
    logic        mark;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc = RPC;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return {{(32-AW){1'b0}}, byte_addr[AW+1:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{mark: 1'b0, pc: next_pc});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic cyc();
    @(posedge system_clock);
    #1;
    topup();
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    next_pc = RPC;
    #1;
    chk("rst_async_valid", 32'(instr_valid), 32'd0);
    chk("rst_async_pc", instr_pc, 32'd0);
    repeat (n) cyc();
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    exp_q.push_back('{mark: 1'b1, pc: 32'd0});
    next_pc = t & 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] p, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc();
      @(negedge system_clock);
      if (instr_valid && instr_pc == p) found = 1'b1;
    end
    chk(name, 32'(found), 32'd1);
  endtask

  // Monitor: occupancy model, issue/valid timing, stability, and in-order stream scoreboard.
  initial begin
    int          m_count;
    int          m_inflight;
    int          acc;
    int          quiet;
    bit          exp_en;
    bit          hold;
    bit          tb_fault;
    logic [31:0] fetch_pc;
    logic [31:0] held_pc;
    logic [31:0] held_instr;
    exp_t        e;
    m_count = 0; m_inflight = 0; quiet = 0; hold = 1'b0; tb_fault = 1'b0;
    fetch_pc = RPC; held_pc = '0; held_instr = '0;
    forever begin
      @(negedge system_clock);
      if (!reset) begin
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_en", 32'(imem_en), 32'd0);
`ifdef IFU_MISALIGN_TRAP_EN
        chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        m_count = 0; m_inflight = 0; quiet = 0; hold = 1'b0; tb_fault = 1'b0;
        fetch_pc = RPC;
      end else begin
        acc = (m_count != 0 && instr_ready) ? 1 : 0;
        chk("valid", 32'(instr_valid), 32'(m_count != 0));
        if (quiet > 0) begin
          chk("redir_bubble", 32'(instr_valid), 32'd0);
          quiet--;
        end
        if (hold) begin
          chk("stall_pc", instr_pc, held_pc);
          chk("stall_instr", instr, held_instr);
        end
        exp_en = !redirect_valid && !tb_fault && (m_count + m_inflight - acc < DEPTH);
        chk("imem_en", 32'(imem_en), 32'(exp_en));
        if (imem_en && exp_en) chk("imem_addr", 32'(imem_addr), 32'(fetch_pc[AW+1:2]));
`ifdef IFU_MISALIGN_TRAP_EN
        chk("fault", 32'(fetch_fault), 32'(tb_fault));
`endif
        if (acc != 0) begin
          if (exp_q.size() == 0 || exp_q[0].mark) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual pc=%h required none", instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e.pc);
            chk("sb_instr", instr, word_at(e.pc));
          end
        end
        hold       = instr_valid && !instr_ready && !redirect_valid;
        held_pc    = instr_pc;
        held_instr = instr;
        if (redirect_valid) begin
          while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.mark) break;
          end
          m_count = 0; m_inflight = 0; quiet = 2;
          fetch_pc = redirect_target & 32'hFFFF_FFFC;
`ifdef IFU_MISALIGN_TRAP_EN
          tb_fault = (redirect_target[1:0] != 2'b00);
`endif
        end else begin
          m_count    = m_count + m_inflight - acc;
          m_inflight = exp_en ? 1 : 0;
          if (exp_en) fetch_pc = fetch_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    logic [31:0] t;
    int          r;
    repeat (3) cyc();
    @(negedge system_clock);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // Stall from the first fetch, then release.
    cyc();
    instr_ready = 1'b0;
    reset       = 1'b1;
    @(negedge system_clock);
    chk("first_en", 32'(imem_en), 32'd1);
    t = RPC;
    chk("first_addr", 32'(imem_addr), 32'(t[AW+1:2]));
    repeat (6) cyc();
    @(negedge system_clock);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_en", 32'(imem_en), 32'd0);
    chk("full_pc", instr_pc, RPC);
    chk("full_instr", instr, word_at(RPC));
    cyc();
    instr_ready = 1'b1;

    // Run across the memory-depth wrap.
    wait_head(32'h40, 40, "wrap_found");
    chk("wrap_instr", instr, 32'd0);

    // Reset mid-stream.
    cyc();
    do_reset(2);
    wait_head(RPC, 6, "restart_found");

    // Redirect with a full buffer holding 0x8.
    wait_head(RPC + 32'h4, 4, "head4_found");
    cyc();
    instr_ready = 1'b0;
    cyc();
    cyc();
    @(negedge system_clock);
    chk("pre_redir_pc", instr_pc, RPC + 32'h8);
    chk("pre_redir_en", 32'(imem_en), 32'd0);
    cyc();
    redirect(32'h40);
    instr_ready = 1'b1;
    wait_head(32'h40, 4, "redir_found");

`ifdef IFU_MISALIGN_TRAP_EN
    cyc();
    redirect(32'h42);
    @(negedge system_clock);
    chk("trap_fault", 32'(fetch_fault), 32'd1);
    chk("trap_en", 32'(imem_en), 32'd0);
    repeat (3) cyc();
    redirect(32'h80);
    wait_head(32'h80, 2, "trap_clear_found");
    chk("trap_cleared", 32'(fetch_fault), 32'd0);
`endif

    // Random traffic.
    cyc();
    for (int n = 0; n < 800; n++) begin
      r           = int'($urandom_range(0, 99));
      instr_ready = ($urandom_range(0, 3) != 0);
      if (r < 2) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (r < 10) begin
        t = $urandom;
`ifdef IFU_MISALIGN_TRAP_EN
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
        redirect(t);
      end else begin
        cyc();
      end
    end
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
